// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
package bru_pkg;

    localparam int unsigned BRU_DEPTH = 4;
    localparam int unsigned BRU_CNT_W = 16;
    localparam int unsigned PTR_W     = $clog2(BRU_DEPTH);
    localparam int unsigned OCC_W     = $clog2(BRU_DEPTH + 1);

    // One in-flight prediction; room left for future tag fields.
    typedef struct packed {
        logic pred;
    } bru_entry_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order store of in-flight predictions with occupancy and synchronous clear.
// A clear wins over a push or pop in the same cycle.
module bru_pred_fifo
    import bru_pkg::*;
#(
    parameter  int unsigned DEPTH = BRU_DEPTH,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  bru_entry_t    push_data,
    input  logic          pop,
    input  logic          clear,
    output bru_entry_t    rd_data_c,
    output logic [CW-1:0] count,
    output logic          ready
);

    bru_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && ready;
    assign do_pop    = pop && (count != '0);
    assign rd_data_c = mem[rd_ptr];

    // Next occupancy: clear empties, push and pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Storage, pointers and registered occupancy/ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_data;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            count <= count_nxt;
            ready <= (count_nxt < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued branch predictions against execute outcomes in order,
// trains the predictor and flags mispredicts.
// Optional statistics counters are built when BRU_STATS_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter  int unsigned DEPTH = BRU_DEPTH,
    parameter  int unsigned CNT_W = BRU_CNT_W,
    localparam int unsigned INF_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic             res_taken,
    output logic             upd_branch,
    output logic             upd_taken,
    output logic             mispredict,
    output logic             res_err,
    output logic [INF_W-1:0] inflight,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    bru_entry_t head;
    bru_entry_t push_entry;
    logic       res_hit;
    logic       res_miss;

    assign push_entry.pred = pred_taken;
    assign res_hit         = res_valid && (inflight != '0);
    assign res_miss        = res_hit && (head.pred != res_taken);

    // A mispredict flushes every younger entry, including a same-cycle push.
    bru_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pred_valid),
        .push_data (push_entry),
        .pop       (res_hit && !res_miss),
        .clear     (res_miss),
        .rd_data_c (head),
        .count     (inflight),
        .ready     (pred_ready)
    );

    // Predictor update and status pulses, one cycle after the resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_branch <= 1'b0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            upd_branch <= res_hit;
            upd_taken  <= res_hit && res_taken;
            mispredict <= res_miss;
            res_err    <= res_valid && (inflight == '0);
        end
    end

`ifdef BRU_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (res_hit && (br_count != CNT_MAX)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (res_miss && (miss_count != CNT_MAX)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end
`else
    assign br_count   = '0;
    assign miss_count = '0;
`endif

endmodule
